c3lib_ckmuxn_sel_seq: RTL and testbench

// - Parametrised N-input clock-select sequencer. Drives the one-hot select and the downstream

---
 rtl/c3lib_ckmux_pkg.sv | 32 +++
 rtl/c3lib_ckmux_dly_cnt.sv | 38 +++
 rtl/c3lib_ckmuxn_sel_seq.sv | 144 ++++++++++++++
 tb/tb_c3lib_ckmuxn_sel_seq.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/c3lib_ckmux_pkg.sv
// Shared types and helpers for the N-input clock-select sequencer.
// Holds the sequencer state encoding, the one-hot decoder and the delay-counter width helper.
package c3lib_ckmux_pkg;

  localparam int unsigned CKMUX_MAX_N = 32;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    GATE_OFF = 2'd1,
    SWITCH   = 2'd2,
    SETTLE   = 2'd3
  } ckmux_seq_st_e;

  // Returns all-zero when idx is not a legal input of an n-input mux.
  function automatic logic [CKMUX_MAX_N-1:0] onehot_dec(input int unsigned idx,
                                                        input int unsigned n);
    logic [CKMUX_MAX_N-1:0] dec;
    dec = '0;
    if (idx < n && idx < CKMUX_MAX_N) begin
      dec = {{(CKMUX_MAX_N-1){1'b0}}, 1'b1} << idx;
    end
    return dec;
  endfunction

  function automatic int unsigned cnt_width(input int unsigned off_cyc,
                                            input int unsigned on_cyc);
    int unsigned m;
    m = (off_cyc > on_cyc) ? off_cyc : on_cyc;
    return (m < 1) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/c3lib_ckmux_dly_cnt.sv
// Load / count-down / terminal-count delay counter shared by the gate-off and settle phases.
// Holds at zero once reached; tc is high whenever the count is zero.
module c3lib_ckmux_dly_cnt #(
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             clr,
  input  logic [CNT_W-1:0] load_val,
  output logic             tc
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // NOTE: every variable written in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc = (cnt_q == '0);

endmodule

// File: rtl/c3lib_ckmuxn_sel_seq.sv
// N-input clock-select sequencer: gates the mux output clock off, switches the one-hot select, settles, re-enables.
// Optional macro C3LIB_CKMUX_SEL_STAT_EN adds the saturating switch counter output sel_sw_cnt.
module c3lib_ckmuxn_sel_seq
  import c3lib_ckmux_pkg::*;
#(
  parameter  int NUM_CK  = 4,
  parameter  int OFF_CYC = 4,
  parameter  int ON_CYC  = 4,
  parameter  int RST_SEL = 0,
  localparam int SEL_W   = $clog2(NUM_CK)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sel_req_vld,
  input  logic [SEL_W-1:0]  sel_req_idx,
  output logic              sel_req_rdy,
  output logic [NUM_CK-1:0] ck_sel_onehot,
  output logic              ck_gate_en,
  output logic [SEL_W-1:0]  sel_cur,
  output logic              sel_busy,
  output logic              sel_err,
  input  logic              tst_override,
  input  logic [SEL_W-1:0]  tst_sel
`ifdef C3LIB_CKMUX_SEL_STAT_EN
  ,
  output logic [15:0]       sel_sw_cnt
`endif
);

  localparam int unsigned       NUM_CK_U   = NUM_CK;
  localparam int                CNT_W      = int'(cnt_width(OFF_CYC, ON_CYC));
  localparam logic [CNT_W-1:0]  OFF_LD     = CNT_W'(OFF_CYC - 1);
  localparam logic [CNT_W-1:0]  ON_LD      = CNT_W'(ON_CYC - 1);
  localparam logic [NUM_CK-1:0] RST_ONEHOT = NUM_CK'(onehot_dec(unsigned'(RST_SEL), NUM_CK_U));

  localparam logic [1:0] ST_IDLE     = IDLE;
  localparam logic [1:0] ST_GATE_OFF = GATE_OFF;
  localparam logic [1:0] ST_SWITCH   = SWITCH;
  localparam logic [1:0] ST_SETTLE   = SETTLE;

  logic [1:0]        state_q, state_d;
  logic [SEL_W-1:0]  tgt_q, tgt_d, sel_cur_q;
  logic [NUM_CK-1:0] onehot_q;
  logic              gate_en_q, rdy_q, busy_q, err_q, err_d;
  logic              cnt_load, cnt_clr, cnt_tc, sel_load, idx_legal;
  logic [CNT_W-1:0]  cnt_val;

  assign idx_legal = (32'(sel_req_idx) < NUM_CK_U);

  always_comb begin
    state_d  = state_q;
    tgt_d    = tgt_q;
    cnt_load = 1'b0;
    cnt_val  = '0;
    cnt_clr  = 1'b0;
    sel_load = 1'b0;
    err_d    = 1'b0;
    // Test override abandons any sequence in flight, including a target not yet applied.
    if (tst_override) begin
      state_d = ST_IDLE;
      cnt_clr = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (sel_req_vld) begin
            if (!idx_legal) begin
              err_d = 1'b1;
            end else if (sel_req_idx != sel_cur_q) begin
              tgt_d    = sel_req_idx;
              state_d  = ST_GATE_OFF;
              cnt_load = 1'b1;
              cnt_val  = OFF_LD;
            end
          end
        end
        ST_GATE_OFF: if (cnt_tc) state_d = ST_SWITCH;
        ST_SWITCH: begin
          sel_load = 1'b1;
          state_d  = ST_SETTLE;
          cnt_load = 1'b1;
          cnt_val  = ON_LD;
        end
        ST_SETTLE: if (cnt_tc) state_d = ST_IDLE;
        default:   state_d = ST_IDLE;
      endcase
    end
  end

  c3lib_ckmux_dly_cnt #(.CNT_W(CNT_W)) u_dly_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (cnt_load),
    .clr      (cnt_clr),
    .load_val (cnt_val),
    .tc       (cnt_tc)
  );

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      tgt_q     <= SEL_W'(RST_SEL);
      sel_cur_q <= SEL_W'(RST_SEL);
      onehot_q  <= RST_ONEHOT;
      gate_en_q <= 1'b1;
      rdy_q     <= 1'b1;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      tgt_q     <= tgt_d;
      gate_en_q <= (state_d == ST_IDLE);
      rdy_q     <= (state_d == ST_IDLE);
      busy_q    <= (state_d != ST_IDLE);
      err_q     <= err_d;
      if (sel_load) begin
        sel_cur_q <= tgt_q;
        onehot_q  <= NUM_CK'(onehot_dec(32'(tgt_q), NUM_CK_U));
      end
    end
  end

`ifdef C3LIB_CKMUX_SEL_STAT_EN
  logic [15:0] sw_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sw_cnt_q <= '0;
    end else if (sel_load && sw_cnt_q != 16'hFFFF) begin
      sw_cnt_q <= sw_cnt_q + 16'd1;
    end
  end

  assign sel_sw_cnt = sw_cnt_q;
`endif

  assign ck_sel_onehot = tst_override ? NUM_CK'(onehot_dec(32'(tst_sel), NUM_CK_U)) : onehot_q;
  assign ck_gate_en    = tst_override | gate_en_q;
  assign sel_req_rdy   = ~tst_override & rdy_q;
  assign sel_cur       = sel_cur_q;
  assign sel_busy      = busy_q;
  assign sel_err       = err_q;

endmodule

// File: tb/tb_c3lib_ckmuxn_sel_seq.sv
// Bench for c3lib_ckmuxn_sel_seq: timing-rule model for a 4-input instance plus directed checks
// on a 5-input instance (illegal indices, OFF_CYC=1). Honours C3LIB_CKMUX_SEL_STAT_EN when defined.
module tb_c3lib_ckmuxn_sel_seq;

  localparam int N    = 4;
  localparam int OFF  = 4;
  localparam int ON   = 4;
  localparam int RSEL = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       chk_en = 1'b0;
  int         n_chk = 0;
  int         n_err = 0;

  logic       sel_req_vld = 1'b0;
  logic [1:0] sel_req_idx = 2'd0;
  logic       tst_override = 1'b0;
  logic [1:0] tst_sel = 2'd0;
  logic       sel_req_rdy, ck_gate_en, sel_busy, sel_err;
  logic [3:0] ck_sel_onehot;
  logic [1:0] sel_cur;

  logic       d5_vld = 1'b0;
  logic [2:0] d5_idx = 3'd0;
  logic       d5_ovr = 1'b0;
  logic [2:0] d5_tsel = 3'd0;
  logic       d5_rdy, d5_gate, d5_busy, d5_err;
  logic [4:0] d5_onehot;
  logic [2:0] d5_cur;

`ifdef C3LIB_CKMUX_SEL_STAT_EN
  logic [15:0] sel_sw_cnt, d5_sw_cnt;
`endif

  logic [1:0] b2b_tgt [3] = '{2'd0, 2'd3, 2'd1};

  always #5 clk = ~clk;

  c3lib_ckmuxn_sel_seq #(.NUM_CK(N), .OFF_CYC(OFF), .ON_CYC(ON), .RST_SEL(RSEL)) u_dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .sel_req_vld   (sel_req_vld),
    .sel_req_idx   (sel_req_idx),
    .sel_req_rdy   (sel_req_rdy),
    .ck_sel_onehot (ck_sel_onehot),
    .ck_gate_en    (ck_gate_en),
    .sel_cur       (sel_cur),
    .sel_busy      (sel_busy),
    .sel_err       (sel_err),
    .tst_override  (tst_override),
    .tst_sel       (tst_sel)
`ifdef C3LIB_CKMUX_SEL_STAT_EN
    ,
    .sel_sw_cnt    (sel_sw_cnt)
`endif
  );

  c3lib_ckmuxn_sel_seq #(.NUM_CK(5), .OFF_CYC(1), .ON_CYC(2), .RST_SEL(4)) u_dut5 (
    .clk           (clk),
    .rst_n         (rst_n),
    .sel_req_vld   (d5_vld),
    .sel_req_idx   (d5_idx),
    .sel_req_rdy   (d5_rdy),
    .ck_sel_onehot (d5_onehot),
    .ck_gate_en    (d5_gate),
    .sel_cur       (d5_cur),
    .sel_busy      (d5_busy),
    .sel_err       (d5_err),
    .tst_override  (d5_ovr),
    .tst_sel       (d5_tsel)
`ifdef C3LIB_CKMUX_SEL_STAT_EN
    ,
    .sel_sw_cnt    (d5_sw_cnt)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Model: m_ph counts cycles since acceptance (0 = idle). Gate is low for phases 1..OFF+ON+1,
  // the new select takes effect after phase OFF+1, ready returns after phase OFF+ON+1.
  int m_ph  = 0;
  int m_cur = RSEL;
  int m_tgt = 0;
  int m_sw  = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ph  <= 0;
      m_cur <= RSEL;
      m_sw  <= 0;
    end else if (tst_override) begin
      m_ph <= 0;
    end else if (m_ph == 0) begin
      if (sel_req_vld && int'(sel_req_idx) != m_cur) begin
        m_tgt <= int'(sel_req_idx);
        m_ph  <= 1;
      end
    end else begin
      if (m_ph == OFF + 1) begin
        m_cur <= m_tgt;
        m_sw  <= (m_sw == 65535) ? m_sw : m_sw + 1;
      end
      m_ph <= (m_ph == OFF + ON + 1) ? 0 : m_ph + 1;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      logic [3:0] e_oh;
      e_oh = tst_override ? 4'(32'd1 << tst_sel) : 4'(32'd1 << m_cur);
      check("cmp_onehot", ck_sel_onehot, e_oh);
      check("cmp_gate_en", ck_gate_en, tst_override || m_ph == 0);
      check("cmp_rdy", sel_req_rdy, !tst_override && m_ph == 0);
      check("cmp_busy", sel_busy, m_ph != 0);
      check("cmp_sel_cur", sel_cur, m_cur);
      check("cmp_sel_err", sel_err, 0);
`ifdef C3LIB_CKMUX_SEL_STAT_EN
      check("cmp_sw_cnt", sel_sw_cnt, m_sw);
`endif
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [9:0] g10, r10;
    logic [3:0] oh5, oh6;
    logic [4:0] g5, r5, d5oh2, d5oh3;
    logic       acc, rdy_s;

    repeat (3) @(posedge clk);
    #1;
    check("rst_onehot", ck_sel_onehot, 4'b0100);
    check("rst_gate_en", ck_gate_en, 1'b1);
    check("rst_rdy", sel_req_rdy, 1'b1);
    check("rst_sel_err", sel_err, 1'b0);
    check("rst_sel_cur", sel_cur, 2'd2);
    check("d5_rst_onehot", d5_onehot, 5'b10000);
    rst_n  = 1'b1;
    chk_en = 1'b1;

    // Switch 2 -> 1; the index changes after acceptance must be ignored.
    @(posedge clk); #1;
    sel_req_vld = 1'b1;
    sel_req_idx = 2'd1;
    @(posedge clk);
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      g10[k-1] = ck_gate_en;
      r10[k-1] = sel_req_rdy;
      if (k == 5) oh5 = ck_sel_onehot;
      if (k == 6) oh6 = ck_sel_onehot;
      if (k == 1) begin
        sel_req_vld = 1'b0;
        sel_req_idx = 2'd3;
      end
    end
    check("sw_gate_cycles", g10, 10'b10_0000_0000);
    check("sw_rdy_cycles", r10, 10'b10_0000_0000);
    check("sw_onehot_c5", oh5, 4'b0100);
    check("sw_onehot_c6", oh6, 4'b0010);

    // Same-index request: no sequence.
    @(posedge clk); #1;
    sel_req_vld = 1'b1;
    sel_req_idx = 2'd1;
    @(posedge clk); #1;
    sel_req_vld = 1'b0;
    check("same_gate_en", ck_gate_en, 1'b1);
    check("same_rdy", sel_req_rdy, 1'b1);
    check("same_busy", sel_busy, 1'b0);

    // Override in cycle 3 of GATE_OFF, then release.
    @(posedge clk); #1;
    sel_req_vld = 1'b1;
    sel_req_idx = 2'd0;
    @(posedge clk); #1;
    sel_req_vld = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    check("ovr_pre_gate", ck_gate_en, 1'b0);
    tst_override = 1'b1;
    tst_sel      = 2'd3;
    #1;
    check("ovr_onehot", ck_sel_onehot, 4'b1000);
    check("ovr_gate_en", ck_gate_en, 1'b1);
    check("ovr_rdy", sel_req_rdy, 1'b0);
    @(posedge clk);
    @(posedge clk); #1;
    tst_override = 1'b0;
    tst_sel      = 2'd0;
    #1;
    check("rel_onehot", ck_sel_onehot, 4'b0010);
    check("rel_rdy", sel_req_rdy, 1'b1);
    check("rel_sel_cur", sel_cur, 2'd1);

    // Reset in cycle 7 (SETTLE) of a 1 -> 3 switch.
    @(posedge clk); #1;
    sel_req_vld = 1'b1;
    sel_req_idx = 2'd3;
    @(posedge clk); #1;
    sel_req_vld = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check("settle_onehot", ck_sel_onehot, 4'b1000);
    check("settle_gate_en", ck_gate_en, 1'b0);
    rst_n = 1'b0;
    #1;
    check("arst_onehot", ck_sel_onehot, 4'b0100);
    check("arst_gate_en", ck_gate_en, 1'b1);
    check("arst_sel_cur", sel_cur, 2'd2);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Three back-to-back switches with valid held: 2 -> 0 -> 3 -> 1.
    @(posedge clk); #1;
    sel_req_vld = 1'b1;
    for (int i = 0; i < 3; i++) begin
      sel_req_idx = b2b_tgt[i];
      acc = 1'b0;
      for (int w = 0; w < 40 && !acc; w++) begin
        @(negedge clk);
        rdy_s = sel_req_rdy;
        @(posedge clk);
        acc = rdy_s;
      end
      check($sformatf("b2b_accept%0d", i), acc, 1'b1);
      #1;
    end
    sel_req_vld = 1'b0;
    for (int w = 0; w < 40; w++) begin
      @(negedge clk);
      if (!sel_busy) break;
    end
    check("b2b_idle", sel_busy, 1'b0);
    check("b2b_onehot", ck_sel_onehot, 4'b0010);
`ifdef C3LIB_CKMUX_SEL_STAT_EN
    check("b2b_sw_cnt", sel_sw_cnt, 16'd3);
`endif
    @(posedge clk); #1;
    sel_req_vld = 1'b1;
    sel_req_idx = 2'd1;
    @(posedge clk); #1;
    sel_req_vld = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("b2b_same_gate_en", ck_gate_en, 1'b1);
`ifdef C3LIB_CKMUX_SEL_STAT_EN
    check("b2b_same_sw_cnt", sel_sw_cnt, 16'd3);
`endif

    // 5-input instance: illegal request indices.
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      d5_vld = 1'b1;
      d5_idx = (i == 0) ? 3'd5 : 3'd7;
      @(posedge clk); #1;
      d5_vld = 1'b0;
      check($sformatf("d5_err_pulse%0d", i), d5_err, 1'b1);
      check($sformatf("d5_err_cur%0d", i), d5_cur, 3'd4);
      check($sformatf("d5_err_gate%0d", i), d5_gate, 1'b1);
      check($sformatf("d5_err_rdy%0d", i), d5_rdy, 1'b1);
      @(posedge clk); #1;
      check($sformatf("d5_err_clear%0d", i), d5_err, 1'b0);
    end

    // 5-input instance, OFF_CYC=1 ON_CYC=2: switch 4 -> 0.
    @(posedge clk); #1;
    d5_vld = 1'b1;
    d5_idx = 3'd0;
    @(posedge clk);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      g5[k-1] = d5_gate;
      r5[k-1] = d5_rdy;
      if (k == 2) d5oh2 = d5_onehot;
      if (k == 3) d5oh3 = d5_onehot;
      if (k == 1) d5_vld = 1'b0;
    end
    check("d5_gate_cycles", g5, 5'b10000);
    check("d5_rdy_cycles", r5, 5'b10000);
    check("d5_onehot_c2", d5oh2, 5'b10000);
    check("d5_onehot_c3", d5oh3, 5'b00001);

    // 5-input instance: illegal test select gives an all-zero select.
    @(posedge clk); #1;
    d5_ovr  = 1'b1;
    d5_tsel = 3'd6;
    #1;
    check("d5_ovr_onehot", d5_onehot, 5'b00000);
    check("d5_ovr_gate", d5_gate, 1'b1);
    check("d5_ovr_rdy", d5_rdy, 1'b0);
    @(posedge clk); #1;
    d5_ovr = 1'b0;
    #1;
    check("d5_rel_onehot", d5_onehot, 5'b00001);
    check("d5_rel_rdy", d5_rdy, 1'b1);

    @(posedge clk); #1;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
